// File: rtl/rambus_apb_initiator_if.sv
// rambus_apb_initiator_if: command/response stream and APB3 bus bundle for the RamBus initiator.
interface rambus_apb_initiator_if #(
    parameter int ADDR_WIDTH = 14,
    parameter int DATA_WIDTH = 32
);
    logic                  CmdValid;
    logic                  CmdReady;
    logic                  CmdWrite;
    logic [ADDR_WIDTH-1:0] CmdAddress;
    logic [DATA_WIDTH-1:0] CmdData;
    logic                  RspValid;
    logic                  RspReady;
    logic [DATA_WIDTH-1:0] RspData;
    logic                  RspError;
    logic                  PSEL;
    logic                  PENABLE;
    logic                  PWRITE;
    logic [ADDR_WIDTH-1:0] PADDR;
    logic [DATA_WIDTH-1:0] PWDATA;
    logic [DATA_WIDTH-1:0] PRDATA;
    logic                  PREADY;
    logic                  PSLVERR;

    // Initiator view: consumes commands, produces responses, drives the APB bus.
    modport master (
        input  CmdValid, CmdWrite, CmdAddress, CmdData, RspReady, PRDATA, PREADY, PSLVERR,
        output CmdReady, RspValid, RspData, RspError, PSEL, PENABLE, PWRITE, PADDR, PWDATA
    );

    // Environment view: command source, response sink and APB completer.
    modport slave (
        output CmdValid, CmdWrite, CmdAddress, CmdData, RspReady, PRDATA, PREADY, PSLVERR,
        input  CmdReady, RspValid, RspData, RspError, PSEL, PENABLE, PWRITE, PADDR, PWDATA
    );
endinterface

// File: rtl/rambus_apb_initiator.sv
// rambus_apb_initiator: APB3 initiator driving the DMMainPorts RamBus from a command/response stream.
// Optional ACCESS wait timeout is built in when RAMBUS_INIT_TIMEOUT_EN is defined.
module rambus_apb_initiator #(
    parameter int ADDR_WIDTH     = 14,
    parameter int DATA_WIDTH     = 32,
    parameter int TIMEOUT_CYCLES = 255
) (
    input logic                   clk,
    input logic                   nReset,
    rambus_apb_initiator_if.master bus
);
    typedef enum logic [1:0] {IDLE, SETUP, ACCESS, RESP} state_t;

    state_t                state;
    logic                  cmd_ready;
    logic                  rsp_valid;
    logic [DATA_WIDTH-1:0] rsp_data;
    logic                  rsp_error;
    logic                  psel;
    logic                  penable;
    logic                  pwrite;
    logic [ADDR_WIDTH-1:0] paddr;
    logic [DATA_WIDTH-1:0] pwdata;

    if (TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES > 65535) begin : g_bad_timeout
        $error("TIMEOUT_CYCLES must be within 1..65535");
    end

`ifdef RAMBUS_INIT_TIMEOUT_EN
    // Abort fires on the ACCESS cycle whose count would reach the limit.
    localparam logic [15:0] TIMEOUT_LAST = 16'(TIMEOUT_CYCLES - 1);
    logic [15:0] wait_cnt;
`endif

    assign bus.CmdReady = cmd_ready;
    assign bus.RspValid = rsp_valid;
    assign bus.RspData  = rsp_data;
    assign bus.RspError = rsp_error;
    assign bus.PSEL     = psel;
    assign bus.PENABLE  = penable;
    assign bus.PWRITE   = pwrite;
    assign bus.PADDR    = paddr;
    assign bus.PWDATA   = pwdata;

    // Transfer sequencer: IDLE -> SETUP -> ACCESS -> RESP, all outputs registered here.
    always_ff @(posedge clk or negedge nReset) begin
        if (!nReset) begin
            state     <= IDLE;
            cmd_ready <= 1'b1;
            rsp_valid <= 1'b0;
            rsp_data  <= '0;
            rsp_error <= 1'b0;
            psel      <= 1'b0;
            penable   <= 1'b0;
            pwrite    <= 1'b0;
            paddr     <= '0;
            pwdata    <= '0;
`ifdef RAMBUS_INIT_TIMEOUT_EN
            wait_cnt  <= '0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (bus.CmdValid) begin
                        pwrite    <= bus.CmdWrite;
                        paddr     <= bus.CmdAddress;
                        pwdata    <= bus.CmdData;
                        psel      <= 1'b1;
                        cmd_ready <= 1'b0;
                        state     <= SETUP;
                    end
                end
                SETUP: begin
                    penable  <= 1'b1;
                    state    <= ACCESS;
`ifdef RAMBUS_INIT_TIMEOUT_EN
                    wait_cnt <= '0;
`endif
                end
                ACCESS: begin
                    if (bus.PREADY) begin
                        rsp_data  <= pwrite ? '0 : bus.PRDATA;
                        rsp_error <= bus.PSLVERR;
                        psel      <= 1'b0;
                        penable   <= 1'b0;
                        rsp_valid <= 1'b1;
                        state     <= RESP;
                    end
`ifdef RAMBUS_INIT_TIMEOUT_EN
                    else if (wait_cnt == TIMEOUT_LAST) begin
                        rsp_data  <= '0;
                        rsp_error <= 1'b1;
                        psel      <= 1'b0;
                        penable   <= 1'b0;
                        rsp_valid <= 1'b1;
                        state     <= RESP;
                    end else begin
                        wait_cnt  <= wait_cnt + 16'd1;
                    end
`endif
                end
                RESP: begin
                    if (bus.RspReady) begin
                        rsp_valid <= 1'b0;
                        cmd_ready <= 1'b1;
                        state     <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_rambus_apb_initiator.sv
// tb_rambus_apb_initiator: directed stimulus with a response scoreboard for rambus_apb_initiator.
module tb_rambus_apb_initiator;
    localparam int AW = 14;
    localparam int DW = 32;

    typedef struct packed {
        logic [31:0] d;
        logic        e;
    } rsp_t;

    logic clk = 1'b0;
    logic nReset = 1'b0;
    int   checks = 0;
    int   failures = 0;
    rsp_t exp_q[$];

    int          wait_n = 0;
    int          acc_cnt = 0;
    logic [31:0] rd_data = '0;
    logic        err_in = 1'b0;
    int          low_run = 0;
    int          last_gap = 0;

    always #5 clk = ~clk;

    rambus_apb_initiator_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus ();

    rambus_apb_initiator #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .TIMEOUT_CYCLES(8)) dut (
        .clk(clk),
        .nReset(nReset),
        .bus(bus)
    );

    // Completer: PREADY after wait_n ACCESS cycles; junk PRDATA and PSLVERR=1 while not ready.
    assign bus.PREADY  = bus.PSEL && bus.PENABLE && (acc_cnt >= wait_n);
    assign bus.PRDATA  = bus.PREADY ? rd_data : 32'hBAD0_BAD0;
    assign bus.PSLVERR = bus.PREADY ? err_in : 1'b1;

    // Count ACCESS cycles already spent waiting.
    always @(posedge clk) acc_cnt <= (bus.PSEL && bus.PENABLE && !bus.PREADY) ? acc_cnt + 1 : 0;

    // Length of the most recent PSEL-low gap, latched when PSEL rises again.
    always @(negedge clk) begin
        if (!bus.PSEL) low_run <= low_run + 1;
        else begin
            if (low_run > 0) last_gap <= low_run;
            low_run <= 0;
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Scoreboard monitor: pop and compare on every response handshake.
    always begin
        rsp_t e;
        @(negedge clk);
        #2;
        if (nReset && bus.RspValid && bus.RspReady) begin
            if (exp_q.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL stray_rsp: got response data 0x%0h with none expected", bus.RspData);
            end else begin
                e = exp_q.pop_front();
                chk("rsp_data", bus.RspData, e.d);
                chk("rsp_error", bus.RspError, e.e);
            end
        end
    end

    // Present one command and return at the negedge after it is accepted.
    task automatic issue(input logic w, input logic [AW-1:0] a, input logic [31:0] d,
                         input logic [31:0] ed, input logic ee);
        int n = 0;
        exp_q.push_back({ed, ee});
        bus.CmdValid   = 1'b1;
        bus.CmdWrite   = w;
        bus.CmdAddress = a;
        bus.CmdData    = d;
        while (!bus.CmdReady && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (n >= 50) begin
            checks++;
            failures++;
            $display("FAIL cmd_accept_timeout: got CmdReady=0 for %0d cycles expected 1", n);
        end
        @(negedge clk);
        bus.CmdValid = 1'b0;
    endtask

    initial begin
        int en_cnt;
        int bad;
        int held;
        int stray;
        int rv;
        bus.CmdValid   = 1'b0;
        bus.CmdWrite   = 1'b0;
        bus.CmdAddress = '0;
        bus.CmdData    = '0;
        bus.RspReady   = 1'b1;
        repeat (2) @(negedge clk);
        chk("rst_cmd_ready", bus.CmdReady, 1);
        chk("rst_rsp_valid", bus.RspValid, 0);
        chk("rst_rsp_data", bus.RspData, 0);
        chk("rst_rsp_error", bus.RspError, 0);
        chk("rst_psel", bus.PSEL, 0);
        chk("rst_penable", bus.PENABLE, 0);
        chk("rst_pwrite", bus.PWRITE, 0);
        chk("rst_paddr", 32'(bus.PADDR), 0);
        chk("rst_pwdata", bus.PWDATA, 0);
        nReset = 1'b1;
        @(negedge clk);
        chk("post_rst_cmd_ready", bus.CmdReady, 1);

        // Write with zero-wait completer.
        wait_n = 0;
        rd_data = 32'h9999_9999;
        issue(1'b1, 14'h0010, 32'hDEAD_BEEF, 32'h0, 1'b0);
        chk("t1_psel", bus.PSEL, 1);
        chk("t1_penable_setup", bus.PENABLE, 0);
        chk("t1_pwrite", bus.PWRITE, 1);
        chk("t1_paddr", 32'(bus.PADDR), 32'h10);
        chk("t1_pwdata", bus.PWDATA, 32'hDEAD_BEEF);
        chk("t1_cmd_ready_busy", bus.CmdReady, 0);
        @(negedge clk);
        chk("t1_penable_access", bus.PENABLE, 1);
        chk("t1_rsp_valid_early", bus.RspValid, 0);
        @(negedge clk);
        chk("t1_rsp_valid", bus.RspValid, 1);
        chk("t1_psel_drop", bus.PSEL, 0);
        chk("t1_penable_drop", bus.PENABLE, 0);
        @(negedge clk);
        chk("t1_idle_ready", bus.CmdReady, 1);
        chk("t1_rsp_clear", bus.RspValid, 0);
        chk("t1_paddr_hold", 32'(bus.PADDR), 32'h10);
        chk("t1_pwdata_hold", bus.PWDATA, 32'hDEAD_BEEF);

        // Read with 5 wait states.
        wait_n = 5;
        rd_data = 32'h1234_5678;
        issue(1'b0, 14'h0004, 32'h0, 32'h1234_5678, 1'b0);
        en_cnt = 0;
        bad = 0;
        repeat (12) begin
            if (bus.PENABLE) en_cnt++;
            if (bus.PSEL && (bus.PADDR != 14'h0004 || bus.PWRITE)) bad++;
            @(negedge clk);
        end
        chk("t2_penable_cycles", en_cnt, 6);
        chk("t2_addr_stable", bad, 0);

        // Slave error with a stalled response sink.
        wait_n = 0;
        err_in = 1'b1;
        rd_data = 32'hCAFE_F00D;
        bus.RspReady = 1'b0;
        issue(1'b0, 14'h0020, 32'h0, 32'hCAFE_F00D, 1'b1);
        @(negedge clk);
        @(negedge clk);
        chk("t3_rsp_valid", bus.RspValid, 1);
        held = 0;
        repeat (4) begin
            @(negedge clk);
            if (bus.RspValid && bus.RspError && bus.RspData == 32'hCAFE_F00D) held++;
        end
        chk("t3_rsp_held", held, 4);
        bus.RspReady = 1'b1;
        @(negedge clk);
        chk("t3_rsp_clear", bus.RspValid, 0);
        chk("t3_cmd_ready", bus.CmdReady, 1);
        err_in = 1'b0;

        // Reset asserted mid-ACCESS.
        wait_n = 1000;
        issue(1'b1, 14'h0030, 32'h55AA_55AA, 32'h0, 1'b0);
        @(negedge clk);
        chk("t4_in_access", bus.PENABLE, 1);
        #1 nReset = 1'b0;
        #1;
        chk("t4_psel_async", bus.PSEL, 0);
        chk("t4_penable_async", bus.PENABLE, 0);
        exp_q.delete();
        @(negedge clk);
        @(negedge clk);
        nReset = 1'b1;
        wait_n = 0;
        stray = 0;
        repeat (6) begin
            @(negedge clk);
            if (bus.RspValid || !bus.CmdReady || bus.PSEL) stray++;
        end
        chk("t4_no_stray", stray, 0);

`ifdef RAMBUS_INIT_TIMEOUT_EN
        // Completer never ready: abort after 8 ACCESS cycles.
        wait_n = 1000;
        rd_data = 32'h7777_7777;
        issue(1'b0, 14'h0050, 32'h0, 32'h0, 1'b1);
        en_cnt = 0;
        repeat (14) begin
            if (bus.PENABLE) en_cnt++;
            @(negedge clk);
        end
        chk("t5_abort_cycles", en_cnt, 8);
        // Ready on the 8th ACCESS cycle wins over the timeout.
        wait_n = 7;
        rd_data = 32'hA5A5_A5A5;
        issue(1'b0, 14'h0054, 32'h0, 32'hA5A5_A5A5, 1'b0);
        en_cnt = 0;
        repeat (14) begin
            if (bus.PENABLE) en_cnt++;
            @(negedge clk);
        end
        chk("t5_limit_complete_cycles", en_cnt, 8);
`else
        // Without the timeout, ACCESS waits as long as the completer stalls.
        wait_n = 1000;
        rd_data = 32'h0BAD_CAFE;
        issue(1'b0, 14'h0058, 32'h0, 32'h0BAD_CAFE, 1'b0);
        en_cnt = 0;
        rv = 0;
        repeat (30) begin
            @(negedge clk);
            if (bus.PENABLE) en_cnt++;
            if (bus.RspValid) rv++;
        end
        chk("t5_wait_forever", en_cnt, 30);
        chk("t5_no_early_rsp", rv, 0);
        wait_n = 0;
        repeat (3) @(negedge clk);
`endif

        // Back-to-back commands with the response sink always ready.
        wait_n = 0;
        rd_data = 32'h2222_2222;
        issue(1'b1, 14'h0040, 32'h1111_1111, 32'h0, 1'b0);
        issue(1'b0, 14'h0044, 32'h0, 32'h2222_2222, 1'b0);
        @(negedge clk);
        @(negedge clk);
        chk("t6_psel_gap", last_gap, 2);
        chk("t6_second_paddr", 32'(bus.PADDR), 32'h44);
        repeat (5) @(negedge clk);

        chk("queue_empty", exp_q.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
